turn_signal_input_cond: RTL

//  Front-end stage for the tail-light sequencer. It conditions the three raw driver

---
 rtl/turn_signal_input_cond_if.sv | 20 ++
 rtl/turn_signal_input_cond.sv | 114 +++++++++++
 2 files changed

// File: rtl/turn_signal_input_cond_if.sv
// rtl/turn_signal_input_cond_if.sv - raw driver switches in, clean request levels and step tick out
interface turn_signal_input_cond_if;
    logic left_raw;
    logic right_raw;
    logic hazard_raw;
    logic L;
    logic R;
    logic H;
    logic tick;

    modport master (
        output left_raw, right_raw, hazard_raw,
        input  L, R, H, tick
    );

    modport slave (
        input  left_raw, right_raw, hazard_raw,
        output L, R, H, tick
    );
endinterface

// File: rtl/turn_signal_input_cond.sv
// rtl/turn_signal_input_cond.sv - synchronise, debounce and arbitrate turn switches; pace sequencer steps
module turn_signal_input_cond #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_DIV        = 4
) (
    input logic                      clk,
    input logic                      reset,
    turn_signal_input_cond_if.slave  bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {STABLE0, PEND1, STABLE1, PEND0} db_state_e;

    logic [2:0] raw;
    logic [2:0] clean_d;

    assign raw = {bus.hazard_raw, bus.right_raw, bus.left_raw};

    // Channel order: 0 = left, 1 = right, 2 = hazard.
    for (genvar g = 0; g < 3; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        db_state_e              state_q, state_d;
        logic [CW-1:0]          cnt_q, cnt_d;
        logic                   s;

        assign s = sync_q[SYNC_STAGES-1];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_q  <= '0;
                state_q <= STABLE0;
                cnt_q   <= '0;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], raw[g]};
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                STABLE0: if (s) begin
                    state_d = PEND1;
                    cnt_d   = CW'(1);
                end
                PEND1: begin
                    if (!s) begin
                        state_d = STABLE0;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
                        state_d = STABLE1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                STABLE1: if (!s) begin
                    state_d = PEND0;
                    cnt_d   = CW'(1);
                end
                PEND0: begin
                    if (s) begin
                        state_d = STABLE1;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
                        state_d = STABLE0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = STABLE0;
                    cnt_d   = '0;
                end
            endcase
        end

        // Arbitration registers the next clean level so acceptance and output share one edge.
        assign clean_d[g] = (state_d == STABLE1) || (state_d == PEND0);
    end

    logic          l_q, r_q, h_q, tick_q;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick_wrap;

    assign tick_wrap  = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + TW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            l_q        <= 1'b0;
            r_q        <= 1'b0;
            h_q        <= 1'b0;
            tick_q     <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            h_q        <= clean_d[2] | (clean_d[0] & clean_d[1]);
            l_q        <= clean_d[0] & ~clean_d[1] & ~clean_d[2];
            r_q        <= clean_d[1] & ~clean_d[0] & ~clean_d[2];
            tick_q     <= tick_wrap;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign bus.L    = l_q;
    assign bus.R    = r_q;
    assign bus.H    = h_q;
    assign bus.tick = tick_q;
endmodule
